touch_sample_ctrl: RTL
======================

TOUCH_SAMPLE_CTRL -- requirements
Module: touch_sample_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 50000, meaning clock cycles between successive X/Y sample-pair starts (1 ms at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles from ADC_START to ADC_DONE before the pair is aborted.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PENIRQ_n, input, 1 bit: touch-panel pen-down, active-low, asynchronous to CLK.
REQ-006 SHALL have port ADC_START, output, 1 bit: single-cycle conversion request pulse.
REQ-007 SHALL have port ADC_CH, output, 1 bit: channel select, 0 = X, 1 = Y; held stable from ADC_START until ADC_DONE.
REQ-008 SHALL have port ADC_DONE, input, 1 bit: single-cycle pulse, with ADC_DATA valid in the same cycle.
REQ-009 SHALL have port ADC_DATA, input, 12 bits: conversion result.
REQ-010 SHALL have ports X_COORD and Y_COORD, output, 12 bits each: last committed coordinates, which feed the 7-segment conversion block.
REQ-011 SHALL have port COORD_VALID, output, 1 bit: one-cycle pulse in the cycle after the coordinate registers update.
REQ-012 SHALL have port TOUCHED, output, 1 bit: synchronized pen-down level.
REQ-013 SHALL have port ERR, output, 1 bit: sticky timeout flag, cleared only by reset.

Function
REQ-014 SHALL synchronize PENIRQ_n through a 2-flop synchronizer; TOUCHED = NOT of the synchronized value, giving 2-cycle latency.
REQ-015 SHALL implement states IDLE, WAIT_PER, START_X, WAIT_X, START_Y, WAIT_Y and COMMIT.
REQ-016 SHALL transition IDLE -> START_X in the cycle TOUCHED is first seen high.
REQ-017 In START_X, SHALL assert ADC_START with ADC_CH=0 for exactly one cycle, then go to WAIT_X.
REQ-018 In WAIT_X, on ADC_DONE, SHALL capture ADC_DATA into an X holding register and go to START_Y.
REQ-019 START_Y and WAIT_Y SHALL behave as START_X and WAIT_X, with ADC_CH=1 and capture into a Y holding register; on ADC_DONE go to COMMIT.
REQ-020 In COMMIT, SHALL copy both holding registers to X_COORD/Y_COORD together in one cycle (never a mixed pair), then go to WAIT_PER; COORD_VALID pulses the next cycle.
REQ-021 SHALL use a period counter of width ceil(log2(SAMPLE_PERIOD)) that restarts at 0 on every entry to START_X; WAIT_PER -> START_X when the count reaches SAMPLE_PERIOD-1 and TOUCHED=1.
REQ-022 If TOUCHED=0 in WAIT_PER, SHALL go to IDLE.
REQ-023 If TOUCHED falls during WAIT_X or WAIT_Y, SHALL wait for ADC_DONE, discard the pair (no COMMIT, no COORD_VALID), then go to IDLE.
REQ-024 SHALL use a timeout counter that restarts at START_X/START_Y; if it reaches TIMEOUT-1 without ADC_DONE: set ERR, discard the pair, go to IDLE.
REQ-025 ADC_DONE arriving in the same cycle as the timeout SHALL be treated as success.
REQ-026 SHALL ignore ADC_DONE outside WAIT_X/WAIT_Y.
REQ-027 SHALL retain X_COORD/Y_COORD across pen-up, aborts and errors.

Reset
REQ-028 On RST_n=0, SHALL asynchronously set: state IDLE, ADC_START=0, ADC_CH=0, X_COORD=0, Y_COORD=0, COORD_VALID=0, ERR=0, all counters 0, synchronizer flops=1 (pen up).
REQ-029 Reset during WAIT_X/WAIT_Y SHALL abandon the conversion; a later stray ADC_DONE SHALL have no effect.

Structure
REQ-030 SHALL place the state encoding, the ADC_CH constants (CH_X=0, CH_Y=1) and the default SAMPLE_PERIOD/TIMEOUT values in a shared package used by the top-level and the testbench.
REQ-031 SHALL place the 2-flop synchronizer in a sub-module named sync_2ff; all other logic is flat.

Verification
REQ-032 Pen down, ADC model returning DONE after 20 cycles with X=0x3A5 then Y=0x1F0 -> X_COORD=0x3A5, Y_COORD=0x1F0, one COORD_VALID pulse, ADC_CH=0 then 1.
REQ-033 Pen held with SAMPLE_PERIOD=100 -> ADC_START with ADC_CH=0 exactly every 100 cycles, and the count of COORD_VALID pulses equals the count of pairs.
REQ-034 Pen released during WAIT_Y, Y=0x222 -> no COORD_VALID, coordinates keep the prior pair, state returns to IDLE.
REQ-035 ADC never asserts DONE, TIMEOUT=16 -> ERR=1 sixteen cycles after ADC_START, no update, and ERR stays set across later successful pairs.
REQ-036 RST_n pulsed low mid-WAIT_X, then a stray DONE with 0xFFF -> all outputs 0, coordinates remain 0.
REQ-037 DONE coincident with the timeout cycle -> data captured and ERR stays 0.

Source files
------------

// File: rtl/touch_sample_ctrl_pkg.sv
// touch_sample_ctrl_pkg: shared state encoding, ADC channel codes and parameter defaults
package touch_sample_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_PER, START_X, WAIT_X, START_Y, WAIT_Y, COMMIT} state_t;
   localparam logic CH_X = 1'b0;
   localparam logic CH_Y = 1'b1;
   localparam int SAMPLE_PERIOD_DEF = 50000;
   localparam int TIMEOUT_DEF = 1024;
   localparam int ADC_W = 12;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, resets to 1 so an unpowered pen line reads as pen-up
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic s1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, s1} <= 2'b11;
      else {q, s1} <= {s1, d};
endmodule

// File: rtl/touch_sample_ctrl.sv
// touch_sample_ctrl: periodic X/Y touch-panel sampling through a shared ADC with timeout and abort
module touch_sample_ctrl
   import touch_sample_ctrl_pkg::*;
#(
   parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
   parameter int TIMEOUT       = TIMEOUT_DEF
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             PENIRQ_n,
   output logic             ADC_START,
   output logic             ADC_CH,
   input  logic             ADC_DONE,
   input  logic [ADC_W-1:0] ADC_DATA,
   output logic [ADC_W-1:0] X_COORD,
   output logic [ADC_W-1:0] Y_COORD,
   output logic             COORD_VALID,
   output logic             TOUCHED,
   output logic             ERR
);
   localparam int PW = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_t           state, state_n;
   logic             pen_sync, drop, pen_lost, in_wait, in_conv, timeout;
   logic [PW-1:0]    pcnt;
   logic [TW-1:0]    tcnt;
   logic [ADC_W-1:0] x_hold, y_hold;

   sync_2ff u_sync (.clk(CLK), .rst_n(RST_n), .d(PENIRQ_n), .q(pen_sync));

   assign TOUCHED   = ~pen_sync;
   assign in_wait   = state == WAIT_X || state == WAIT_Y;
   assign in_conv   = in_wait || state == START_X || state == START_Y;
   assign ADC_START = state == START_X || state == START_Y;
   assign ADC_CH    = (state == START_Y || state == WAIT_Y) ? CH_Y : CH_X;
   assign pen_lost  = drop | ~TOUCHED;
   // a DONE landing on the last allowed cycle still counts as success
   assign timeout   = in_wait && !ADC_DONE && tcnt == T_LAST;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = TOUCHED ? START_X : IDLE;
         WAIT_PER: state_n = !TOUCHED ? IDLE : (pcnt == P_LAST ? START_X : WAIT_PER);
         START_X:  state_n = WAIT_X;
         WAIT_X:   state_n = ADC_DONE ? (pen_lost ? IDLE : START_Y) : (timeout ? IDLE : WAIT_X);
         START_Y:  state_n = WAIT_Y;
         WAIT_Y:   state_n = ADC_DONE ? (pen_lost ? IDLE : COMMIT) : (timeout ? IDLE : WAIT_Y);
         COMMIT:   state_n = WAIT_PER;
         default:  state_n = IDLE;
      endcase
   end

   // period count saturates so a pair overrunning the period restarts at once
   always_ff @(posedge CLK or negedge RST_n)
      if (!RST_n) begin
         state       <= IDLE;
         pcnt        <= '0;
         tcnt        <= '0;
         drop        <= 1'b0;
         x_hold      <= '0;
         y_hold      <= '0;
         X_COORD     <= '0;
         Y_COORD     <= '0;
         COORD_VALID <= 1'b0;
         ERR         <= 1'b0;
      end else begin
         state       <= state_n;
         pcnt        <= state_n == START_X ? '0 : (pcnt == P_LAST ? pcnt : pcnt + 1'b1);
         tcnt        <= (state_n == START_X || state_n == START_Y) ? '0 : tcnt + 1'b1;
         drop        <= state_n == START_X ? 1'b0 : drop | (in_conv & ~TOUCHED);
         if (state == WAIT_X && ADC_DONE) x_hold <= ADC_DATA;
         if (state == WAIT_Y && ADC_DONE) y_hold <= ADC_DATA;
         if (state == COMMIT) begin
            X_COORD <= x_hold;
            Y_COORD <= y_hold;
         end
         COORD_VALID <= state == COMMIT;
         ERR         <= ERR | timeout;
      end
endmodule
